alu_seq: RTL
============

# alu_seq

Parametrised, handshaked successor to the team's combinational 8-op ALU. Single-cycle ops (add, sub, not, xor, or, and) complete in one cycle. Multiply and divide run as iterative multi-cycle operations and return a full double-width result. Status flags are added. The block sits between the datapath sequencer and the register file, using valid/ready on both sides, so it can stall upstream while a long operation runs.

## Interface
Parameters:
- DATA_WIDTH, 16, operand/result width; must be ≥ 2.
- HIGH, DATA_WIDTH-1, MSB index of the data buses.

Ports:
- clk  input  1  clock; everything sampled on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept a request.
- oc  input  3  opcode: 000 add, 001 sub, 010 mul, 011 div, 100 not(a), 101 xor, 110 or, 111 and.
- a  input  DATA_WIDTH  operand A.
- b  input  DATA_WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- f  output  DATA_WIDTH  result low word; quotient for div.
- f_hi  output  DATA_WIDTH  mul: upper product word; div: remainder; other ops: 0.
- flag_z  output  1  f == 0.
- flag_c  output  1  add: carry out; sub: borrow (a < b unsigned); mul: f_hi != 0; otherwise 0.
- flag_v  output  1  add/sub: signed two's-complement overflow; otherwise 0.
- flag_dz  output  1  div with b == 0; otherwise 0.

## Operation
- State machine with three states: IDLE, BUSY, DONE.
- in_ready = 1 only in IDLE.
- An accept is in_valid && in_ready. On an accept, oc, a and b are registered.
- IDLE → DONE on an accept of ops 000, 001, 100–111. The result is computed from the registered operands.
- IDLE → BUSY on an accept of mul or div. An iteration counter is loaded with DATA_WIDTH-1.
- BUSY performs one iteration per cycle: shift-add for mul, restoring shift-subtract for div, both unsigned. At counter 0, BUSY → DONE.
- Div by zero does not iterate. IDLE → DONE directly with f = all ones, f_hi = a, flag_dz = 1.
- In DONE, out_valid = 1. f, f_hi and the flags are held stable until out_ready. The cycle with out_valid && out_ready is the transfer; the block returns to IDLE on the next edge.
- No new request is accepted in BUSY or DONE. in_valid asserted there is ignored and must be held by the upstream logic.
- The unsigned arithmetic wraps modulo 2^DATA_WIDTH in f. Carry and borrow come from a (DATA_WIDTH+1)-bit add/subtract.
- For sub, flag_v = (a[HIGH] != b[HIGH]) && (f[HIGH] != a[HIGH]).
- Output registers (f, f_hi, flags) update only on entry to DONE.

## Timing
- Reset (asynchronous):
  - state = IDLE, so in_ready = 1.
  - out_valid = 0.
  - f, f_hi and all flags = 0.
  - Counter and operand registers = 0.
- Reset mid-operation aborts BUSY or DONE with no result emitted.
- Latency, counted from the accept edge to the first out_valid cycle:
  - single-cycle ops and div by zero: 1 cycle.
  - mul and div: DATA_WIDTH + 1 cycles.
- Peak throughput is one op per 2 cycles. With out_ready tied high, a single-cycle op gives in_ready 1,0,1.
- Backpressure: out_valid and the data stay constant for any number of cycles with out_ready = 0.

## Structure
- Shared package alu_pkg holds:
  - the opcode constants (OP_ADD … OP_AND);
  - the state encoding IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - The 8-op encoding is unchanged, so existing decoders reuse it.
- One sub-module, alu_iter, holds the iterative unit: the counter, the partial-product/remainder registers, and a start/done pulse interface. The top level owns the FSM, the single-cycle ops and the flags.

## Test plan
All scenarios use DATA_WIDTH=16.
1. Reset, then add a=16'hFFFF, b=16'h0001 → after 1 cycle: f=0, flag_z=1, flag_c=1, flag_v=0, f_hi=0.
2. Sub a=16'h8000, b=16'h0001 → f=16'h7FFF, flag_v=1, flag_c=0. Sub a=3, b=5 → f=16'hFFFE, flag_c=1.
3. Mul a=16'h1234, b=16'h0100 → out_valid exactly 17 cycles after accept, {f_hi,f}=32'h00123400, flag_c=1. in_ready = 0 throughout.
4. Div a=1000, b=7 → f=142, f_hi=6 at 17 cycles. Div a=16'h00AA, b=0 → after 1 cycle: f=16'hFFFF, f_hi=16'h00AA, flag_dz=1.
5. Backpressure: xor result with out_ready=0 for 5 cycles → outputs stable, in_ready=0, and a new in_valid is ignored. out_ready=1 → IDLE next cycle, then the pending request is accepted.
6. Assert rst in the 8th BUSY cycle of a mul → immediately out_valid=0, all outputs 0, in_ready=1. No stale result appears after rst is released.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcode, state and flag definitions for the sequential ALU
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_AND = 3'b111;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef struct packed {
        logic z;
        logic c;
        logic v;
        logic dz;
    } alu_flags_t;

    // Multiply and divide are the only ops handed to the iterative unit
    function automatic logic is_iter_op(input logic [2:0] oc);
        return (oc == OP_MUL) || (oc == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/result handshake bundle between sequencer, ALU and register file
interface alu_seq_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            oc;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] f;
    logic [DATA_WIDTH-1:0] f_hi;
    logic                  flag_z;
    logic                  flag_c;
    logic                  flag_v;
    logic                  flag_dz;

    modport master (
        output in_valid, oc, a, b, out_ready,
        input  in_ready, out_valid, f, f_hi, flag_z, flag_c, flag_v, flag_dz
    );

    modport slave (
        input  in_valid, oc, a, b, out_ready,
        output in_ready, out_valid, f, f_hi, flag_z, flag_c, flag_v, flag_dz
    );
endinterface

// File: rtl/alu_seq_iter.sv
// rtl/alu_seq_iter.sv - iterative unsigned shift-add multiplier / restoring divider
module alu_iter #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_div,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo
);
    localparam int CW = $clog2(DATA_WIDTH);

    logic                  r_busy;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_hi;
    logic [DATA_WIDTH-1:0] r_lo;

    logic                  w_first;
    logic [DATA_WIDTH-1:0] w_hi_cur;
    logic [DATA_WIDTH-1:0] w_lo_cur;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_rem_sh;
    logic [DATA_WIDTH:0]   w_trial;
    logic [DATA_WIDTH-1:0] w_hi_nxt;
    logic [DATA_WIDTH-1:0] w_lo_nxt;

    // One iteration step; operands arrive registered one cycle after start, so the
    // first step seeds the working pair straight from them instead of a load cycle
    always_comb begin
        w_first  = (r_cnt == CW'(DATA_WIDTH - 1));
        w_hi_cur = w_first ? '0  : r_hi;
        w_lo_cur = w_first ? i_a : r_lo;
        w_sum    = {1'b0, w_hi_cur} + (w_lo_cur[0] ? {1'b0, i_b} : '0);
        w_rem_sh = {w_hi_cur, w_lo_cur[DATA_WIDTH-1]};
        w_trial  = w_rem_sh - {1'b0, i_b};
        w_hi_nxt = w_sum[DATA_WIDTH:1];
        w_lo_nxt = {w_sum[0], w_lo_cur[DATA_WIDTH-1:1]};
        if (i_div) begin
            if (!w_trial[DATA_WIDTH]) begin
                w_hi_nxt = w_trial[DATA_WIDTH-1:0];
                w_lo_nxt = {w_lo_cur[DATA_WIDTH-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_rem_sh[DATA_WIDTH-1:0];
                w_lo_nxt = {w_lo_cur[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    // Done is flagged during the last step so the caller captures the final values directly
    assign o_done = r_busy && (r_cnt == '0);
    assign o_hi   = w_hi_nxt;
    assign o_lo   = w_lo_nxt;

    // Counter and working registers, one step per cycle while busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= CW'(DATA_WIDTH - 1);
        end else if (r_busy) begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end
endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with single-cycle logic ops and iterative mul/div
module alu_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int HIGH       = DATA_WIDTH - 1
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    logic [1:0]            r_state;
    logic [2:0]            r_oc;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_f;
    logic [DATA_WIDTH-1:0] r_f_hi;
    alu_flags_t            r_flags;

    logic                  w_accept;
    logic                  w_start;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_diff;
    logic [DATA_WIDTH-1:0] w_res;
    logic [DATA_WIDTH-1:0] w_res_hi;
    alu_flags_t            w_flags;
    alu_flags_t            w_iter_flags;
    logic                  w_iter_done;
    logic [DATA_WIDTH-1:0] w_iter_hi;
    logic [DATA_WIDTH-1:0] w_iter_lo;

    assign w_accept = bus.in_valid && (r_state == IDLE);
    // Divide by zero is resolved immediately and never starts the iterative unit
    assign w_start  = w_accept && is_iter_op(bus.oc) && !((bus.oc == OP_DIV) && (bus.b == '0));

    // Single-cycle results and flags from the operands being accepted
    always_comb begin
        w_sum    = {1'b0, bus.a} + {1'b0, bus.b};
        w_diff   = {1'b0, bus.a} - {1'b0, bus.b};
        w_res    = '0;
        w_res_hi = '0;
        w_flags  = '0;
        case (bus.oc)
            OP_ADD: begin
                w_res     = w_sum[DATA_WIDTH-1:0];
                w_flags.c = w_sum[DATA_WIDTH];
                w_flags.v = (bus.a[HIGH] == bus.b[HIGH]) && (w_res[HIGH] != bus.a[HIGH]);
            end
            OP_SUB: begin
                w_res     = w_diff[DATA_WIDTH-1:0];
                w_flags.c = w_diff[DATA_WIDTH];
                w_flags.v = (bus.a[HIGH] != bus.b[HIGH]) && (w_res[HIGH] != bus.a[HIGH]);
            end
            OP_DIV: begin
                w_res      = '1;
                w_res_hi   = bus.a;
                w_flags.dz = 1'b1;
            end
            OP_NOT:  w_res = ~bus.a;
            OP_XOR:  w_res = bus.a ^ bus.b;
            OP_OR:   w_res = bus.a | bus.b;
            OP_AND:  w_res = bus.a & bus.b;
            default: w_res = '0;
        endcase
        w_flags.z = (w_res == '0);
    end

    // Flags for a finished multiply/divide
    always_comb begin
        w_iter_flags   = '0;
        w_iter_flags.z = (w_iter_lo == '0);
        w_iter_flags.c = (r_oc == OP_MUL) && (w_iter_hi != '0);
    end

    alu_iter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_iter (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_div   (r_oc == OP_DIV),
        .i_a     (r_a),
        .i_b     (r_b),
        .o_done  (w_iter_done),
        .o_hi    (w_iter_hi),
        .o_lo    (w_iter_lo)
    );

    // Control FSM; result registers load only on entry to DONE and hold through backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_oc    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_f     <= '0;
            r_f_hi  <= '0;
            r_flags <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_oc <= bus.oc;
                        r_a  <= bus.a;
                        r_b  <= bus.b;
                        if (w_start) begin
                            r_state <= BUSY;
                        end else begin
                            r_state <= DONE;
                            r_f     <= w_res;
                            r_f_hi  <= w_res_hi;
                            r_flags <= w_flags;
                        end
                    end
                end
                BUSY: begin
                    if (w_iter_done) begin
                        r_state <= DONE;
                        r_f     <= w_iter_lo;
                        r_f_hi  <= w_iter_hi;
                        r_flags <= w_iter_flags;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.f         = r_f;
    assign bus.f_hi      = r_f_hi;
    assign bus.flag_z    = r_flags.z;
    assign bus.flag_c    = r_flags.c;
    assign bus.flag_v    = r_flags.v;
    assign bus.flag_dz   = r_flags.dz;
endmodule
